fft8_twiddle_sequencer: RTL



---
 rtl/fft8_twiddle_sequencer_pkg.sv | 38 +++
 rtl/fft8_twiddle_sequencer_valid_delay.sv | 31 +++
 rtl/fft8_twiddle_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/fft8_twiddle_sequencer_pkg.sv
// fft8_pkg: shared definitions for the 8-point radix-2 DIT FFT twiddle
// sequencer.
//   TW_W             twiddle part width (Q2.10, 1.0 = 1024)
//   TW_ONE, TW_C45   Q2.10 constants for 1.0 and cos(45 deg)
//   stage_e          sequencer state (IDLE, STG0, STG1, STG2)
//   tw_lookup(n, inverse)
//                    W8^n twiddle packed as {re, im}; the sign of im is
//                    flipped for the inverse transform
package fft8_pkg;

  localparam int unsigned TW_W = 12;

  localparam logic signed [TW_W-1:0] TW_ONE = 12'sd1024;
  localparam logic signed [TW_W-1:0] TW_C45 = 12'sd724;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STG0 = 2'd1,
    STG1 = 2'd2,
    STG2 = 2'd3
  } stage_e;

  function automatic logic [2*TW_W-1:0] tw_lookup(input logic [2:0] n,
                                                  input logic       inverse);
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
    case (n)
      3'd1:    begin re = TW_C45;  im = -TW_C45; end
      3'd2:    begin re = '0;      im = -TW_ONE; end
      3'd3:    begin re = -TW_C45; im = -TW_C45; end
      // n = 4..7 never occurs in an 8-point frame
      default: begin re = TW_ONE;  im = '0;      end
    endcase
    if (inverse) im = -im;
    return {re, im};
  endfunction

endpackage

// File: rtl/fft8_twiddle_sequencer_valid_delay.sv
// fft8_valid_delay: shift register that delays a 1-bit strobe by DEPTH
// clock cycles.
//   CLK   clock
//   RST   asynchronous active-high reset, clears the whole line
//   din   strobe in
//   dout  strobe delayed by DEPTH cycles
module fft8_valid_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft8_twiddle_sequencer.sv
// fft8_twiddle_sequencer: takes the 12 lower-leg butterfly samples of one
// 8-point frame (3 stages x 4), pairs each with its W8^n twiddle and
// registers both onto the complex multiplier inputs.
//   CLK, RST                clock, asynchronous active-high reset
//   start                   begins a frame (honoured only in IDLE)
//   in_valid, in_ready      sample handshake; in_ready high in STG0..STG2
//   in_real, in_img         signed sample, DATA_WIDTH each
//   data_real, data_img     registered sample to multiplier IN0
//   tw_real, tw_img         registered Q2.10 twiddle to multiplier IN1
//   out_valid, out_stage    output strobe and stage tag (0..2)
//   mul_valid               out_valid delayed MUL_LATENCY (1..4) cycles
//   frame_done              pulses with the output of the 12th sample
module fft8_twiddle_sequencer
  import fft8_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TW_WIDTH    = 12,
  parameter int unsigned MUL_LATENCY = 1,
  parameter bit          INVERSE     = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_img,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_real,
  output logic [DATA_WIDTH-1:0] data_img,
  output logic [TW_WIDTH-1:0]   tw_real,
  output logic [TW_WIDTH-1:0]   tw_img,
  output logic                  out_valid,
  output logic [1:0]            out_stage,
  output logic                  mul_valid,
  output logic                  frame_done
);

  stage_e             state;
  logic [1:0]         k;
  logic               accept;
  logic [2:0]         n;
  logic [1:0]         stage_idx;
  stage_e             next_stage;
  logic [2*TW_W-1:0]  tw;
  logic signed [TW_W-1:0] tw_re;
  logic signed [TW_W-1:0] tw_im;

  assign in_ready = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    n          = 3'd0;
    stage_idx  = 2'd0;
    next_stage = IDLE;
    case (state)
      STG0: begin n = 3'd0;          stage_idx = 2'd0; next_stage = STG1; end
      STG1: begin n = {k[0], 1'b0};  stage_idx = 2'd1; next_stage = STG2; end
      STG2: begin n = {1'b0, k};     stage_idx = 2'd2; next_stage = IDLE; end
      default: ;
    endcase
  end

  assign tw    = tw_lookup(n, INVERSE);
  assign tw_re = tw[2*TW_W-1:TW_W];
  assign tw_im = tw[TW_W-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      k          <= '0;
      data_real  <= '0;
      data_img   <= '0;
      tw_real    <= '0;
      tw_img     <= '0;
      out_valid  <= 1'b0;
      out_stage  <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= accept;
      frame_done <= accept && (state == STG2) && (k == 2'd3);
      if (state == IDLE) begin
        if (start) state <= STG0;
      end else if (accept) begin
        // k wraps 3->0 by overflow exactly when the stage advances
        k <= k + 2'd1;
        if (k == 2'd3) state <= next_stage;
      end
      if (accept) begin
        data_real <= in_real;
        data_img  <= in_img;
        tw_real   <= TW_WIDTH'(tw_re);
        tw_img    <= TW_WIDTH'(tw_im);
        out_stage <= stage_idx;
      end
    end
  end

  fft8_valid_delay #(
    .DEPTH(MUL_LATENCY)
  ) u_mul_dly (
    .CLK  (CLK),
    .RST  (RST),
    .din  (out_valid),
    .dout (mul_valid)
  );

endmodule
